sdram_stream_sequencer: RTL and testbench
=========================================

Name: sdram_stream_sequencer

Overview:
- Command-driven sequencer that drives the SDRAM read-master and write-master control/user conduits of the Qsys system.
- Three modes:
  - FILL: write an incrementing pattern.
  - CHECK: read back and compare against the pattern.
  - COPY: read a region and write it to another region.
- Sits in fabric between test/control logic and the Qsys SDRAM master conduits.
- Generalises the fixed 16-bit, single-purpose master hookup to parametrised data width with error reporting.

Parameters:
- DATA_W, 16, word width of the user buffer ports (multiple of 8).
- ADDR_W, 32, byte address width of base outputs.
- LEN_W, 32, byte length width.
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_mode  in  2  0=FILL 1=CHECK 2=COPY 3=reserved
- cmd_src  in  ADDR_W  read base, bytes
- cmd_dst  in  ADDR_W  write base, bytes
- cmd_len  in  LEN_W  length, bytes
- cmd_seed  in  DATA_W  pattern start value
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- cmd_err  out  1  valid with done; command rejected
- err_count  out  ERR_W  CHECK mismatches, saturating
- first_err_addr  out  ADDR_W  byte address of first mismatch
- rd_fixed_location  out  1  tied 0
- rd_read_base  out  ADDR_W  read base
- rd_read_length  out  LEN_W  read length
- rd_go  out  1  read start pulse
- rd_done  in  1  read master done
- rd_early_done  in  1  unused, ignored
- rd_read_buffer  out  1  pop read FIFO
- rd_buffer_output_data  in  DATA_W  read FIFO head (look-ahead)
- rd_data_available  in  1  read FIFO non-empty
- wr_fixed_location  out  1  tied 0
- wr_write_base  out  ADDR_W  write base
- wr_write_length  out  LEN_W  write length
- wr_go  out  1  write start pulse
- wr_done  in  1  write master done
- wr_write_buffer  out  1  push write FIFO
- wr_buffer_input_data  out  DATA_W  push data
- wr_buffer_full  in  1  write FIFO full

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1; state IDLE.
- BPW = DATA_W/8. Word count N = cmd_len/BPW.
- States: IDLE, LAUNCH, STREAM, WAIT_DONE, FINISH.
- IDLE:
  - Accepts a command when cmd_valid && cmd_ready.
  - Registers mode, src, dst, len and seed; clears err_count and first_err_addr.
  - mode 3, or cmd_len not a multiple of BPW: go to FINISH with cmd_err=1 and no go pulses.
  - cmd_len=0: go to FINISH with cmd_err=0 and no go pulses.
  - Otherwise: go to LAUNCH.
- LAUNCH (one cycle, the cycle after accept):
  - rd_go=1 for CHECK/COPY; wr_go=1 for FILL/COPY.
  - Base/length outputs are registered and held stable until FINISH.
- STREAM, word index k from 0 to N-1:
  - FILL: wr_write_buffer=1 when !wr_buffer_full, with data = seed+k mod 2^DATA_W; k advances on each push.
  - CHECK: rd_read_buffer=1 when rd_data_available. Data is compared the same cycle against seed+k. On mismatch, err_count increments (saturating at all-ones) and, on the first mismatch, first_err_addr = src + k*BPW.
  - COPY: pop and push in the same cycle only when rd_data_available && !wr_buffer_full, forwarding rd_buffer_output_data combinationally to wr_buffer_input_data. No word is dropped or duplicated under any backpressure.
  - After N transfers, go to WAIT_DONE.
- WAIT_DONE:
  - Sticky flags latch rd_done and wr_done; they may arrive in any order or in the same cycle, including during STREAM.
  - Exit to FINISH once every launched master has reported done.
- FINISH: done=1 for one cycle, then IDLE.
- busy is high in every state except IDLE.
- err_count and first_err_addr hold until the next accept.
- Reset mid-operation: returns to reset values immediately. Masters must be reset by the same system reset; this block does not flush them.
- rd_early_done is ignored.

Decomposition:
- Package sdram_stream_pkg: mode encodings (MODE_FILL, MODE_CHECK, MODE_COPY), state enum.
- One sub-module, sdram_stream_pattern: holds the seed+k generator, compare, saturating error counter and first-error capture. Shared by FILL (generate) and CHECK (compare).

Test Plan:
- FILL, dst=0x100, len=8, seed=0xA000 -> wr_go one cycle after accept with base 0x100 and length 8. Pushes 0xA000, 0xA001, 0xA002, 0xA003. Done one cycle after wr_done; cmd_err=0.
- CHECK, src=0x100, len=8, seed=0xA000, with the word at k=2 returned as 0xFFFF -> err_count=1, first_err_addr=0x104.
- COPY, len=16, wr_buffer_full toggled every 3 cycles and rd_data_available gapped -> eight words delivered in order, no duplicates, done only after both rd_done and wr_done (tested in both orders and simultaneous).
- Rejects:
  - cmd_len=3 -> done with cmd_err=1, no go pulses.
  - mode=3 -> done with cmd_err=1, no go pulses.
  - len=0 -> done with cmd_err=0, no go pulses.
- Wrap and saturation: seed=0xFFFE, FILL len=8 -> data 0xFFFE, 0xFFFF, 0x0000, 0x0001. With ERR_W=2 and 5 mismatches, err_count=3.
- Reset asserted mid-STREAM -> next cycle busy=0, cmd_ready=1, all go/buffer strobes 0.

Source files
------------

// File: rtl/sdram_stream_pkg.sv
// Shared encodings for the SDRAM stream sequencer: command modes, FSM states
// and small mode-decoding helpers.
package sdram_stream_pkg;

    typedef enum logic [1:0] {
        MODE_FILL  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_COPY  = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_STREAM,
        ST_WAIT_DONE,
        ST_FINISH
    } state_e;

    // Modes that need the read master.
    function automatic logic mode_reads(input mode_e m);
        return (m == MODE_CHECK) || (m == MODE_COPY);
    endfunction

    // Modes that need the write master.
    function automatic logic mode_writes(input mode_e m);
        return (m == MODE_FILL) || (m == MODE_COPY);
    endfunction

endpackage

// File: rtl/sdram_stream_sequencer_if.sv
// Read-master and write-master conduits of the Qsys SDRAM masters.
// The sequencer is the master side; the Qsys conduits are the slave side.
interface sdram_stream_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 32
);
    logic              rd_fixed_location;
    logic [ADDR_W-1:0] rd_read_base;
    logic [LEN_W-1:0]  rd_read_length;
    logic              rd_go;
    logic              rd_done;
    logic              rd_early_done;
    logic              rd_read_buffer;
    logic [DATA_W-1:0] rd_buffer_output_data;
    logic              rd_data_available;

    logic              wr_fixed_location;
    logic [ADDR_W-1:0] wr_write_base;
    logic [LEN_W-1:0]  wr_write_length;
    logic              wr_go;
    logic              wr_done;
    logic              wr_write_buffer;
    logic [DATA_W-1:0] wr_buffer_input_data;
    logic              wr_buffer_full;

    modport master (
        output rd_fixed_location, rd_read_base, rd_read_length, rd_go, rd_read_buffer,
        input  rd_done, rd_early_done, rd_buffer_output_data, rd_data_available,
        output wr_fixed_location, wr_write_base, wr_write_length, wr_go, wr_write_buffer,
        output wr_buffer_input_data,
        input  wr_done, wr_buffer_full
    );

    modport slave (
        input  rd_fixed_location, rd_read_base, rd_read_length, rd_go, rd_read_buffer,
        output rd_done, rd_early_done, rd_buffer_output_data, rd_data_available,
        input  wr_fixed_location, wr_write_base, wr_write_length, wr_go, wr_write_buffer,
        input  wr_buffer_input_data,
        output wr_done, wr_buffer_full
    );

endinterface

// File: rtl/sdram_stream_pattern.sv
// Incrementing pattern generator (seed+k) with word compare, saturating
// mismatch counter and first-mismatch byte address capture.
module sdram_stream_pattern #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,      // command accepted: restart at seed/base
    input  logic [DATA_W-1:0] seed,
    input  logic [ADDR_W-1:0] base,
    input  logic              advance,   // one word transferred this cycle
    input  logic              compare,   // word on data is checked this cycle
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] pattern,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr
);
    localparam int BPW = DATA_W / 8;

    logic [ADDR_W-1:0] addr;      // byte address of word k
    logic              mismatch;

    assign mismatch = compare && (data != pattern);

    // Pattern/address step per word; error counter saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern        <= '0;
            addr           <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (load) begin
            pattern        <= seed;
            addr           <= base;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            if (advance) begin
                pattern <= pattern + 1'b1;
                addr    <= addr + ADDR_W'(BPW);
            end
            if (mismatch) begin
                if (err_count != '1)
                    err_count <= err_count + 1'b1;
                // The counter only leaves zero on the first mismatch.
                if (err_count == '0)
                    first_err_addr <= addr;
            end
        end
    end

endmodule

// File: rtl/sdram_stream_sequencer.sv
// Command-driven FILL / CHECK / COPY sequencer for the Qsys SDRAM read and
// write master conduits.
module sdram_stream_sequencer
    import sdram_stream_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 32,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_seed,
    output logic              busy,
    output logic              done,
    output logic              cmd_err,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    sdram_stream_sequencer_if.master bus
);
    localparam int BPW = DATA_W / 8;

    state_e            state;
    mode_e             mode;
    mode_e             cmd_mode_e;
    logic              need_rd, need_wr, rd_seen, wr_seen;
    logic              rd_go_q, wr_go_q;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  len_q, remaining;
    logic              accept, len_bad, all_done;
    logic              pop, push, xfer;
    logic [DATA_W-1:0] wdata, pattern;
    logic              unused_early_done;

    assign cmd_mode_e = mode_e'(cmd_mode);
    assign accept     = cmd_valid && cmd_ready;
    assign len_bad    = (cmd_len % LEN_W'(BPW)) != '0;
    assign all_done   = (!need_rd || rd_seen || bus.rd_done) &&
                        (!need_wr || wr_seen || bus.wr_done);
    assign xfer       = pop || push;
    assign unused_early_done = bus.rd_early_done;

    // FIFO strobes react to the same-cycle FIFO status; COPY forwards read data straight through.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        pop   = 1'b0;
        push  = 1'b0;
        wdata = '0;
        if (state == ST_STREAM) begin
            case (mode)
                MODE_FILL: begin
                    push  = !bus.wr_buffer_full;
                    wdata = pattern;
                end
                MODE_CHECK: pop = bus.rd_data_available;
                MODE_COPY: begin
                    pop   = bus.rd_data_available && !bus.wr_buffer_full;
                    push  = pop;
                    wdata = bus.rd_buffer_output_data;
                end
                default: ;
            endcase
        end
    end

    sdram_stream_pattern #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .ERR_W (ERR_W)
    ) u_pattern (
        .clk           (clk),
        .reset         (reset),
        .load          (accept),
        .seed          (cmd_seed),
        .base          (cmd_src),
        .advance       (xfer),
        .compare       (pop && (mode == MODE_CHECK)),
        .data          (bus.rd_buffer_output_data),
        .pattern       (pattern),
        .err_count     (err_count),
        .first_err_addr(first_err_addr)
    );

    // Command FSM with registered handshake, status and go outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            mode      <= MODE_FILL;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            rd_go_q   <= 1'b0;
            wr_go_q   <= 1'b0;
            need_rd   <= 1'b0;
            need_wr   <= 1'b0;
            rd_seen   <= 1'b0;
            wr_seen   <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            remaining <= '0;
        end else begin
            // NOTE: non-blocking updates so every branch below sees pre-edge state.
            rd_go_q <= 1'b0;
            wr_go_q <= 1'b0;
            done    <= 1'b0;
            // Master completions may arrive any time after launch, even mid-stream.
            if (state != ST_IDLE) begin
                rd_seen <= rd_seen || bus.rd_done;
                wr_seen <= wr_seen || bus.wr_done;
            end
            case (state)
                ST_IDLE: if (accept) begin
                    mode      <= cmd_mode_e;
                    src_q     <= cmd_src;
                    dst_q     <= cmd_dst;
                    len_q     <= cmd_len;
                    remaining <= cmd_len / LEN_W'(BPW);
                    need_rd   <= mode_reads(cmd_mode_e);
                    need_wr   <= mode_writes(cmd_mode_e);
                    rd_seen   <= 1'b0;
                    wr_seen   <= 1'b0;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    if (cmd_mode_e == MODE_RSVD || len_bad) begin
                        state   <= ST_FINISH;
                        done    <= 1'b1;
                        cmd_err <= 1'b1;
                    end else if (cmd_len == '0) begin
                        state <= ST_FINISH;
                        done  <= 1'b1;
                    end else begin
                        state   <= ST_LAUNCH;
                        rd_go_q <= mode_reads(cmd_mode_e);
                        wr_go_q <= mode_writes(cmd_mode_e);
                    end
                end
                ST_LAUNCH: state <= ST_STREAM;
                ST_STREAM: if (xfer) begin
                    remaining <= remaining - 1'b1;
                    if (remaining == LEN_W'(1))
                        state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: if (all_done) begin
                    state <= ST_FINISH;
                    done  <= 1'b1;
                end
                ST_FINISH: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    cmd_err   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rd_fixed_location    = 1'b0;
    assign bus.rd_read_base         = src_q;
    assign bus.rd_read_length       = len_q;
    assign bus.rd_go                = rd_go_q;
    assign bus.rd_read_buffer       = pop;
    assign bus.wr_fixed_location    = 1'b0;
    assign bus.wr_write_base        = dst_q;
    assign bus.wr_write_length      = len_q;
    assign bus.wr_go                = wr_go_q;
    assign bus.wr_write_buffer      = push;
    assign bus.wr_buffer_input_data = wdata;

endmodule

// File: tb/tb_sdram_stream_sequencer.sv
// Self-checking bench: a table of commands, a bench-side read/write master
// model, and a scoreboard queue of expected write-FIFO words.
module tb_sdram_stream_sequencer;

    localparam int ERR_W = 2;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic [31:0] cmd_src, cmd_dst, cmd_len;
    logic [15:0] cmd_seed;
    logic        busy, done, cmd_err;
    logic [ERR_W-1:0] err_count;
    logic [31:0] first_err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];   // words the write FIFO must receive, in order
    logic [15:0] rd_src[$];  // words the read FIFO presents, in order

    sdram_stream_sequencer_if #(.DATA_W(16), .ADDR_W(32), .LEN_W(32)) bus ();

    sdram_stream_sequencer #(
        .DATA_W(16), .ADDR_W(32), .LEN_W(32), .ERR_W(ERR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_mode      (cmd_mode),
        .cmd_src       (cmd_src),
        .cmd_dst       (cmd_dst),
        .cmd_len       (cmd_len),
        .cmd_seed      (cmd_seed),
        .busy          (busy),
        .done          (done),
        .cmd_err       (cmd_err),
        .err_count     (err_count),
        .first_err_addr(first_err_addr),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] src, dst, len;
        logic [15:0] seed;
        logic [15:0] bad_mask;  // CHECK: word k returned as 16'hFFFF
        bit          stress;    // FIFO backpressure and read gaps
        bit          early;     // master dones pulse in the first stream cycle
        int          rd_dly, wr_dly;
        bit          exp_err;
        logic [ERR_W-1:0] exp_errs;
        logic [31:0] exp_first;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [1:0] mode, input logic [31:0] src, dst, len,
                                input logic [15:0] seed, bad_mask, input bit stress, early,
                                input int rd_dly, wr_dly, input bit exp_err,
                                input logic [ERR_W-1:0] exp_errs, input logic [31:0] exp_first);
        vec_t v;
        v.mode = mode; v.src = src; v.dst = dst; v.len = len; v.seed = seed;
        v.bad_mask = bad_mask; v.stress = stress; v.early = early;
        v.rd_dly = rd_dly; v.wr_dly = wr_dly; v.exp_err = exp_err;
        v.exp_errs = exp_errs; v.exp_first = exp_first;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid                 = 1'b0;
        bus.rd_done               = 1'b0;
        bus.wr_done               = 1'b0;
        bus.rd_early_done         = 1'b0;
        bus.rd_data_available     = 1'b0;
        bus.rd_buffer_output_data = 16'h0;
        bus.wr_buffer_full        = 1'b0;
    endtask

    task automatic run_cmd(input vec_t v, input int idx);
        int n, c, comp_cyc, done_cyc, rd_pulse, wr_pulse, xfers, rd_go_n, wr_go_n, later, exp_done;
        bit rej, nrd, nwr;
        logic [15:0] w;
        string p;
        p   = $sformatf("v%0d", idx);
        n   = int'(v.len / 2);
        rej = (v.mode == 2'd3) || v.len[0] || (v.len == 0);
        nrd = !rej && (v.mode == 2'd1 || v.mode == 2'd2);
        nwr = !rej && (v.mode == 2'd0 || v.mode == 2'd2);
        exp_q.delete();
        rd_src.delete();
        if (!rej) begin
            for (int k = 0; k < n; k++) begin
                case (v.mode)
                    2'd0: exp_q.push_back(v.seed + 16'(k));
                    2'd1: rd_src.push_back(v.bad_mask[k] ? 16'hFFFF : v.seed + 16'(k));
                    default: begin
                        w = 16'($urandom);
                        rd_src.push_back(w);
                        exp_q.push_back(w);
                    end
                endcase
            end
        end

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mode  = v.mode;
        cmd_src   = v.src;
        cmd_dst   = v.dst;
        cmd_len   = v.len;
        cmd_seed  = v.seed;
        #1 check({p, "_ready_idle"}, cmd_ready, 1);

        c = 0; comp_cyc = -1; done_cyc = -1; xfers = 0; rd_go_n = 0; wr_go_n = 0;
        rd_pulse = v.early ? 2 : -1;
        wr_pulse = v.early ? 2 : -1;
        while (done_cyc < 0 && c < 400) begin
            @(negedge clk);
            c++;
            cmd_valid                 = 1'b0;
            bus.wr_buffer_full        = v.stress && ((c / 3) % 2 == 1);
            bus.rd_data_available     = (rd_src.size() > 0) && !(v.stress && (c % 4 == 3));
            bus.rd_buffer_output_data = bus.rd_data_available ? rd_src[0] : 16'h0;
            bus.rd_done               = nrd && (c == rd_pulse);
            bus.wr_done               = nwr && (c == wr_pulse);
            bus.rd_early_done         = (c % 2 == 1);
            #1;
            if (c == 1) begin
                check({p, "_busy"}, busy, 1);
                check({p, "_ready_low"}, cmd_ready, 0);
                check({p, "_rd_go"}, bus.rd_go, nrd);
                check({p, "_wr_go"}, bus.wr_go, nwr);
                if (nrd) begin
                    check({p, "_rd_base"}, bus.rd_read_base, v.src);
                    check({p, "_rd_len"}, bus.rd_read_length, v.len);
                end
                if (nwr) begin
                    check({p, "_wr_base"}, bus.wr_write_base, v.dst);
                    check({p, "_wr_len"}, bus.wr_write_length, v.len);
                end
            end
            rd_go_n += int'(bus.rd_go);
            wr_go_n += int'(bus.wr_go);
            if (v.mode == 2'd2 && (bus.rd_read_buffer || bus.wr_write_buffer))
                check({p, "_copy_lockstep"}, bus.rd_read_buffer, bus.wr_write_buffer);
            if (bus.rd_read_buffer) begin
                check({p, "_pop_avail"}, bus.rd_data_available, 1);
                if (bus.rd_data_available) begin
                    w = rd_src.pop_front();
                    if (v.mode == 2'd1) xfers++;
                end
            end
            if (bus.wr_write_buffer) begin
                check({p, "_push_not_full"}, bus.wr_buffer_full, 0);
                check({p, "_push_expected"}, exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check({p, "_push_data"}, bus.wr_buffer_input_data, w);
                end
                xfers++;
            end
            if (!rej && comp_cyc < 0 && xfers == n) begin
                comp_cyc = c;
                if (!v.early) begin
                    rd_pulse = c + v.rd_dly;
                    wr_pulse = c + v.wr_dly;
                end
            end
            if (done) begin
                done_cyc = c;
                if (rej) exp_done = 1;
                else begin
                    later = 0;
                    if (nrd && rd_pulse > later) later = rd_pulse;
                    if (nwr && wr_pulse > later) later = wr_pulse;
                    exp_done = (later + 1 > comp_cyc + 2) ? later + 1 : comp_cyc + 2;
                end
                check({p, "_done_cycle"}, c, exp_done);
                check({p, "_cmd_err"}, cmd_err, v.exp_err);
                check({p, "_rd_go_count"}, rd_go_n, nrd);
                check({p, "_wr_go_count"}, wr_go_n, nwr);
                check({p, "_words_moved"}, xfers, rej ? 0 : n);
                check({p, "_pushes_left"}, exp_q.size(), 0);
                if (nwr) check({p, "_wr_base_held"}, bus.wr_write_base, v.dst);
                if (nrd) check({p, "_rd_base_held"}, bus.rd_read_base, v.src);
            end
        end
        check({p, "_done_seen"}, done_cyc >= 0, 1);

        @(negedge clk);
        idle_inputs();
        #1;
        check({p, "_done_pulse_end"}, done, 0);
        check({p, "_busy_end"}, busy, 0);
        check({p, "_ready_end"}, cmd_ready, 1);
        check({p, "_err_count"}, err_count, v.exp_errs);
        check({p, "_first_err_addr"}, first_err_addr, v.exp_first);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        //          mode   src       dst       len     seed      mask      st ea rd wr err errs first
        vecs[0]  = mk(2'd0, 32'h0,   32'h100,  32'd8,  16'hA000, 16'h0,    0, 0, 1, 1, 0, 0, 32'h0);
        vecs[1]  = mk(2'd1, 32'h100, 32'h0,    32'd8,  16'hA000, 16'h0004, 0, 0, 2, 1, 0, 1, 32'h104);
        vecs[2]  = mk(2'd1, 32'h300, 32'h0,    32'd12, 16'h1234, 16'h003E, 1, 0, 1, 1, 0, 3, 32'h302);
        vecs[3]  = mk(2'd0, 32'h0,   32'h100,  32'd3,  16'h0,    16'h0,    0, 0, 1, 1, 1, 0, 32'h0);
        vecs[4]  = mk(2'd3, 32'h0,   32'h100,  32'd8,  16'h0,    16'h0,    0, 0, 1, 1, 1, 0, 32'h0);
        vecs[5]  = mk(2'd0, 32'h0,   32'h100,  32'd0,  16'h0,    16'h0,    0, 0, 1, 1, 0, 0, 32'h0);
        vecs[6]  = mk(2'd2, 32'h200, 32'h400,  32'd16, 16'h0,    16'h0,    1, 0, 1, 3, 0, 0, 32'h0);
        vecs[7]  = mk(2'd2, 32'h200, 32'h400,  32'd16, 16'h0,    16'h0,    1, 0, 4, 1, 0, 0, 32'h0);
        vecs[8]  = mk(2'd2, 32'h200, 32'h400,  32'd16, 16'h0,    16'h0,    1, 0, 2, 2, 0, 0, 32'h0);
        vecs[9]  = mk(2'd2, 32'h200, 32'h400,  32'd16, 16'h0,    16'h0,    1, 1, 1, 1, 0, 0, 32'h0);
        vecs[10] = mk(2'd0, 32'h0,   32'h500,  32'd8,  16'hFFFE, 16'h0,    1, 0, 1, 2, 0, 0, 32'h0);
        vecs[11] = mk(2'd1, 32'h700, 32'h0,    32'd8,  16'hFFFE, 16'h0,    1, 0, 3, 1, 0, 0, 32'h0);

        idle_inputs();
        cmd_mode = 2'd0; cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_seed = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_go", bus.rd_go, 0);
        check("reset_wr_go", bus.wr_go, 0);
        check("reset_err_count", err_count, 0);
        check("reset_wr_base", bus.wr_write_base, 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_cmd(vecs[i], i);

        // Reset in the middle of a FILL stream.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_dst = 32'h600; cmd_len = 32'd16; cmd_seed = 16'h55;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #1 check("mid_stream_push", bus.wr_write_buffer, 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", cmd_ready, 1);
        check("rst_mid_push", bus.wr_write_buffer, 0);
        check("rst_mid_pop", bus.rd_read_buffer, 0);
        check("rst_mid_wr_go", bus.wr_go, 0);
        check("rst_mid_rd_go", bus.rd_go, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_wr_base", bus.wr_write_base, 0);
        reset = 1'b0;

        // Normal operation resumes after the reset.
        run_cmd(vecs[0], 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
